// File: rtl/wb_unified_mem_arbiter_pkg.sv
// Shared encodings for the unified instruction/data memory arbiter:
// FSM states, grant codes and the wait counter width.
package wb_unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GNT_I = 2'b01,
        ARB_GNT_D = 2'b10
    } arb_state_e;

    typedef enum logic {
        MST_I = 1'b0,
        MST_D = 1'b1
    } master_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    localparam int WAIT_CNT_W = 8;

    function automatic logic [1:0] grant_code(input arb_state_e state);
        case (state)
            ARB_GNT_I: return GRANT_I;
            ARB_GNT_D: return GRANT_D;
            default:   return GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Saturating wait counter for a granted transfer; flags expiry when the
// count reaches TIMEOUT (a TIMEOUT of 0 never expires).
module wb_arb_timeout
    import wb_unified_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT      = WAIT_CNT_W'(TIMEOUT);
    localparam bit                    TIMEOUT_EN = (TIMEOUT != 0);

    logic [WAIT_CNT_W-1:0] wait_cnt_d, wait_cnt_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear) begin
            wait_cnt_d = '0;
        end else if (enable && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign expired = TIMEOUT_EN && (wait_cnt_q == LIMIT);

endmodule

// File: rtl/wb_unified_mem_arbiter.sv
// Two-master (instruction fetch, data) to one-slave Wishbone classic arbiter
// with alternating grants under contention and a stalled-slave timeout.
module wb_unified_mem_arbiter
    import wb_unified_mem_arbiter_pkg::*;
#(
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int TIMEOUT = 255,
    localparam int SEL_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] iwb_adr_i,
    input  logic              iwb_cyc_i,
    input  logic              iwb_stb_i,
    output logic [DATA_W-1:0] iwb_dat_o,
    output logic              iwb_ack_o,
    output logic              iwb_err_o,
    input  logic [ADDR_W-1:0] dwb_adr_i,
    input  logic [DATA_W-1:0] dwb_dat_i,
    input  logic              dwb_we_i,
    input  logic [SEL_W-1:0]  dwb_sel_i,
    input  logic              dwb_cyc_i,
    input  logic              dwb_stb_i,
    output logic [DATA_W-1:0] dwb_dat_o,
    output logic              dwb_ack_o,
    output logic              dwb_err_o,
    output logic [ADDR_W-1:0] mwb_adr_o,
    output logic [DATA_W-1:0] mwb_dat_o,
    output logic              mwb_we_o,
    output logic [SEL_W-1:0]  mwb_sel_o,
    output logic              mwb_cyc_o,
    output logic              mwb_stb_o,
    input  logic [DATA_W-1:0] mwb_dat_i,
    input  logic              mwb_ack_i,
    input  logic              mwb_err_i,
    output logic [1:0]        grant_o
);

    arb_state_e state_d, state_q;
    master_e    last_grant_d, last_grant_q;
    logic       i_req, d_req, mwb_resp, expired;

    assign i_req    = iwb_cyc_i & iwb_stb_i;
    assign d_req    = dwb_cyc_i & dwb_stb_i;
    assign mwb_resp = mwb_ack_i | mwb_err_i;

    wb_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == ARB_IDLE),
        .enable  ((state_q != ARB_IDLE) && !mwb_resp),
        .expired (expired)
    );

    // Any exit from a grant (response, timeout or master abort) records its owner.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (i_req && d_req) begin
                    state_d = (last_grant_q == MST_I) ? ARB_GNT_D : ARB_GNT_I;
                end else if (i_req) begin
                    state_d = ARB_GNT_I;
                end else if (d_req) begin
                    state_d = ARB_GNT_D;
                end
            end
            ARB_GNT_I: begin
                if (!iwb_cyc_i || expired || mwb_resp) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = MST_I;
                end
            end
            ARB_GNT_D: begin
                if (!dwb_cyc_i || expired || mwb_resp) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = MST_D;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= MST_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant_o = grant_code(state_q);

    // Read data is broadcast; only the owner ever sees a termination strobe.
    assign iwb_dat_o = mwb_dat_i;
    assign dwb_dat_o = mwb_dat_i;

    // Expiry forces cyc/stb low; err wins over a simultaneous ack.
    always_comb begin
        mwb_adr_o = '0;
        mwb_dat_o = '0;
        mwb_we_o  = 1'b0;
        mwb_sel_o = '0;
        mwb_cyc_o = 1'b0;
        mwb_stb_o = 1'b0;
        iwb_ack_o = 1'b0;
        iwb_err_o = 1'b0;
        dwb_ack_o = 1'b0;
        dwb_err_o = 1'b0;
        case (state_q)
            ARB_GNT_I: begin
                mwb_adr_o = iwb_adr_i;
                mwb_sel_o = '1;
                mwb_cyc_o = iwb_cyc_i & ~expired;
                mwb_stb_o = iwb_stb_i & ~expired;
                iwb_err_o = iwb_cyc_i & (expired | mwb_err_i);
                iwb_ack_o = iwb_cyc_i & ~expired & mwb_ack_i & ~mwb_err_i;
            end
            ARB_GNT_D: begin
                mwb_adr_o = dwb_adr_i;
                mwb_dat_o = dwb_dat_i;
                mwb_we_o  = dwb_we_i;
                mwb_sel_o = dwb_sel_i;
                mwb_cyc_o = dwb_cyc_i & ~expired;
                mwb_stb_o = dwb_stb_i & ~expired;
                dwb_err_o = dwb_cyc_i & (expired | mwb_err_i);
                dwb_ack_o = dwb_cyc_i & ~expired & mwb_ack_i & ~mwb_err_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_unified_mem_arbiter.sv
// Bench for wb_unified_mem_arbiter: vector table, directed corner sequences
// and a randomized two-master run scored against a transaction-level model.
module tb_wb_unified_mem_arbiter;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_I    = 2'b01;
    localparam logic [1:0] G_D    = 2'b10;
    localparam logic [31:0] RBASE = 32'h0000_2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] iwb_adr_i, iwb_dat_o;
    logic        iwb_cyc_i, iwb_stb_i, iwb_ack_o, iwb_err_o;
    logic [31:0] dwb_adr_i, dwb_dat_i, dwb_dat_o;
    logic        dwb_we_i, dwb_cyc_i, dwb_stb_i, dwb_ack_o, dwb_err_o;
    logic [3:0]  dwb_sel_i;
    logic [31:0] mwb_adr_o, mwb_dat_o, mwb_dat_i;
    logic        mwb_we_o, mwb_cyc_o, mwb_stb_o, mwb_ack_i, mwb_err_i;
    logic [3:0]  mwb_sel_o;
    logic [1:0]  grant_o;

    wb_unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
        .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o), .iwb_err_o(iwb_err_o),
        .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_we_i(dwb_we_i), .dwb_sel_i(dwb_sel_i),
        .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i),
        .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
        .mwb_adr_o(mwb_adr_o), .mwb_dat_o(mwb_dat_o), .mwb_we_o(mwb_we_o), .mwb_sel_o(mwb_sel_o),
        .mwb_cyc_o(mwb_cyc_o), .mwb_stb_o(mwb_stb_o),
        .mwb_dat_i(mwb_dat_i), .mwb_ack_i(mwb_ack_i), .mwb_err_i(mwb_err_i),
        .grant_o(grant_o)
    );

    // Registered-ack memory: one-cycle ack, optional error injection or stall.
    logic [31:0] mem [0:4095];
    logic        mem_ack, mem_err, mem_no_ack, mem_err_inj;
    logic [31:0] mem_rdata;
    assign mwb_dat_i = mem_rdata;
    assign mwb_ack_i = mem_ack;
    assign mwb_err_i = mem_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ack   <= 1'b0;
            mem_err   <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ack <= 1'b0;
            mem_err <= 1'b0;
            if (mwb_cyc_o && mwb_stb_o && !mem_ack && !mem_no_ack) begin
                mem_ack   <= 1'b1;
                mem_err   <= mem_err_inj;
                mem_rdata <= mem[mwb_adr_o[13:2]];
                if (mwb_we_o && !mem_err_inj)
                    for (int b = 0; b < 4; b++)
                        if (mwb_sel_o[b]) mem[mwb_adr_o[13:2]][8*b +: 8] <= mwb_dat_o[8*b +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic idle_masters();
        iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
        dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; dwb_we_i = 1'b0;
    endtask

    task automatic drive_d(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                           input logic [3:0] sel);
        dwb_adr_i = adr; dwb_dat_i = dat; dwb_we_i = we; dwb_sel_i = sel;
        dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    endtask

    task automatic drive_i(input logic [31:0] adr);
        iwb_adr_i = adr; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    endtask

    task automatic check_quiet(input string name);
        check({name, " grant"}, grant_o, G_NONE);
        check({name, " mwb cyc/stb/we"}, {mwb_cyc_o, mwb_stb_o, mwb_we_o}, 3'b000);
        check({name, " mwb adr/sel"}, {mwb_adr_o, mwb_sel_o}, '0);
        check({name, " acks/errs"}, {iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o}, 4'b0000);
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic        inj_err;
        logic [1:0]  exp_grant;
        logic [3:0]  exp_sel;
        logic [31:0] exp_mdat;
        logic        exp_err;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic is_d, input logic we, input logic [31:0] adr,
                                input logic [31:0] wdat, input logic [3:0] sel, input logic inj_err,
                                input logic [1:0] eg, input logic [3:0] es, input logic [31:0] emd,
                                input logic ee, input logic cr, input logic [31:0] er);
        vec_t v;
        v.is_d = is_d; v.we = we; v.adr = adr; v.wdat = wdat; v.sel = sel; v.inj_err = inj_err;
        v.exp_grant = eg; v.exp_sel = es; v.exp_mdat = emd; v.exp_err = ee;
        v.chk_rdata = cr; v.exp_rdata = er;
        return v;
    endfunction

    // One isolated transfer: grant one cycle after request, response the next.
    task automatic apply_vec(input vec_t v, input int k);
        string t;
        t = $sformatf("vec%0d", k);
        @(negedge clk);
        if (v.is_d) drive_d(v.adr, v.wdat, v.we, v.sel);
        else        drive_i(v.adr);
        mem_err_inj = v.inj_err;
        @(negedge clk);
        check({t, " grant"}, grant_o, v.exp_grant);
        check({t, " mwb adr"}, mwb_adr_o, v.adr);
        check({t, " mwb we/sel"}, {mwb_we_o, mwb_sel_o}, {v.is_d & v.we, v.exp_sel});
        check({t, " mwb dat"}, mwb_dat_o, v.exp_mdat);
        check({t, " mwb cyc/stb"}, {mwb_cyc_o, mwb_stb_o}, 2'b11);
        @(negedge clk);
        check({t, " i ack/err"}, {iwb_ack_o, iwb_err_o},
              v.is_d ? 2'b00 : {~v.exp_err, v.exp_err});
        check({t, " d ack/err"}, {dwb_ack_o, dwb_err_o},
              v.is_d ? {~v.exp_err, v.exp_err} : 2'b00);
        if (v.chk_rdata) check({t, " rdata"}, v.is_d ? dwb_dat_o : iwb_dat_o, v.exp_rdata);
        idle_masters();
        mem_err_inj = 1'b0;
        @(negedge clk);
        check({t, " back to idle"}, grant_o, G_NONE);
    endtask

    task automatic run_random(input int n_each);
        logic [31:0] ref_mem [16];
        logic [31:0] i_adr, d_adr, d_wdat;
        logic [3:0]  d_sel;
        logic        d_we, i_act, d_act, i_prev, d_prev;
        logic [1:0]  g, prev_g, tb_last, exp_g;
        int          i_left, d_left, i_gap, d_gap, i_acks, d_acks, age, cyc;
        logic        exp_iack, exp_dack;
        i_left = n_each; d_left = n_each; i_gap = 0; d_gap = 0; i_acks = 0; d_acks = 0;
        i_act = 1'b0; d_act = 1'b0; i_prev = 1'b0; d_prev = 1'b0;
        prev_g = G_NONE; tb_last = G_I; age = 0; cyc = 0;
        i_adr = RBASE; d_adr = RBASE; d_wdat = '0; d_sel = 4'hF; d_we = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ref_mem[k] = $urandom;
            mem[RBASE[13:2] + k] = ref_mem[k];
        end
        while ((i_left > 0 || d_left > 0 || i_act || d_act) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            g = grant_o;
            age = (g != G_NONE && g == prev_g) ? age + 1 : 0;
            if (prev_g == G_NONE && (i_prev || d_prev || g != G_NONE)) begin
                if (i_prev && d_prev) exp_g = (tb_last == G_I) ? G_D : G_I;
                else if (i_prev)      exp_g = G_I;
                else if (d_prev)      exp_g = G_D;
                else                  exp_g = G_NONE;
                check("rnd grant choice", g, exp_g);
            end else if (prev_g != G_NONE && g != prev_g) begin
                check("rnd grant release", g, G_NONE);
                tb_last = prev_g;
            end
            if (g == G_I) check("rnd i request mux", {mwb_adr_o, mwb_we_o, mwb_sel_o, mwb_dat_o},
                                {i_adr, 1'b0, 4'hF, 32'h0});
            if (g == G_D) check("rnd d request mux", {mwb_adr_o, mwb_we_o, mwb_sel_o, mwb_dat_o},
                                {d_adr, d_we, d_sel, d_wdat});
            exp_iack = (g == G_I) && (age == 1);
            exp_dack = (g == G_D) && (age == 1);
            check("rnd response route", {iwb_ack_o, dwb_ack_o, iwb_err_o, dwb_err_o},
                  {exp_iack, exp_dack, 2'b00});
            if (iwb_ack_o && exp_iack) begin
                check("rnd i rdata", iwb_dat_o, ref_mem[(i_adr - RBASE) >> 2]);
                i_acks++; i_act = 1'b0; i_gap = $urandom_range(0, 3);
            end
            if (dwb_ack_o && exp_dack) begin
                if (d_we) ref_mem[(d_adr - RBASE) >> 2] = merge(ref_mem[(d_adr - RBASE) >> 2], d_wdat, d_sel);
                else      check("rnd d rdata", dwb_dat_o, ref_mem[(d_adr - RBASE) >> 2]);
                d_acks++; d_act = 1'b0; d_gap = $urandom_range(0, 3);
            end
            if (!i_act && i_left > 0) begin
                if (i_gap > 0) i_gap--;
                else begin
                    i_adr = RBASE + 32'(4 * $urandom_range(0, 15));
                    i_act = 1'b1; i_left--;
                end
            end
            if (!d_act && d_left > 0) begin
                if (d_gap > 0) d_gap--;
                else begin
                    d_adr  = RBASE + 32'(4 * $urandom_range(0, 15));
                    d_we   = 1'($urandom_range(0, 1));
                    d_sel  = 4'($urandom_range(1, 15));
                    d_wdat = $urandom;
                    d_act  = 1'b1; d_left--;
                end
            end
            iwb_adr_i = i_adr; iwb_cyc_i = i_act; iwb_stb_i = i_act;
            dwb_adr_i = d_adr; dwb_dat_i = d_wdat; dwb_we_i = d_we; dwb_sel_i = d_sel;
            dwb_cyc_i = d_act; dwb_stb_i = d_act;
            i_prev = i_act; d_prev = d_act; prev_g = g;
        end
        check("rnd finished in budget", cyc < 3000, 1'b1);
        check("rnd i ack count", i_acks, n_each);
        check("rnd d ack count", d_acks, n_each);
    endtask

    vec_t vecs [8];

    initial begin
        int acks_i, acks_d, n_gnt, cyc;
        logic [1:0] pg;

        vecs[0] = mk(0, 0, 32'h100, 32'h0,        4'h0, 0, G_I, 4'hF, 32'h0,        0, 1, 32'h0000_0013);
        vecs[1] = mk(1, 1, 32'h200, 32'hA5A5A5A5, 4'hF, 0, G_D, 4'hF, 32'hA5A5A5A5, 0, 0, 32'h0);
        vecs[2] = mk(1, 0, 32'h200, 32'h55,       4'hF, 0, G_D, 4'hF, 32'h55,       0, 1, 32'hA5A5A5A5);
        vecs[3] = mk(1, 1, 32'h200, 32'h11223344, 4'h4, 0, G_D, 4'h4, 32'h11223344, 0, 0, 32'h0);
        vecs[4] = mk(0, 0, 32'h200, 32'h0,        4'h0, 0, G_I, 4'hF, 32'h0,        0, 1, 32'hA522A5A5);
        vecs[5] = mk(1, 1, 32'h200, 32'hFFFFFFFF, 4'hF, 1, G_D, 4'hF, 32'hFFFFFFFF, 1, 0, 32'h0);
        vecs[6] = mk(0, 0, 32'h200, 32'h0,        4'h0, 0, G_I, 4'hF, 32'h0,        0, 1, 32'hA522A5A5);
        vecs[7] = mk(0, 0, 32'h100, 32'h0,        4'h0, 1, G_I, 4'hF, 32'h0,        1, 0, 32'h0);

        for (int k = 0; k < 4096; k++) mem[k] = '0;
        mem[0]               = 32'hCAFE_0001;
        mem[32'h100 >> 2]    = 32'h0000_0013;
        mem[32'h1000 >> 2]   = 32'h1234_5678;
        mem_no_ack = 1'b0; mem_err_inj = 1'b0;
        iwb_adr_i = '0; dwb_adr_i = '0; dwb_dat_i = '0; dwb_sel_i = '0;
        idle_masters();

        // Reset holds everything quiet even with both masters requesting.
        drive_i(32'h40);
        drive_d(32'h80, 32'h1, 1'b1, 4'hF);
        repeat (3) @(negedge clk);
        check_quiet("reset");
        idle_masters();
        @(negedge clk);
        rst_n = 1'b1;

        // First contention after reset goes to D, then I.
        @(negedge clk);
        drive_i(32'h0);
        drive_d(32'h1000, 32'hDEADBEEF, 1'b1, 4'b0011);
        @(negedge clk);
        check("sim grant D first", grant_o, G_D);
        check("sim d mux", {mwb_adr_o, mwb_dat_o, mwb_we_o, mwb_sel_o},
              {32'h1000, 32'hDEADBEEF, 1'b1, 4'b0011});
        @(negedge clk);
        check("sim d ack", {dwb_ack_o, iwb_ack_o}, 2'b10);
        dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
        @(negedge clk);
        check("sim idle gap", grant_o, G_NONE);
        @(negedge clk);
        check("sim grant I second", {grant_o, mwb_adr_o}, {G_I, 32'h0});
        @(negedge clk);
        check("sim i ack/data", {iwb_ack_o, dwb_ack_o, iwb_dat_o}, {2'b10, 32'hCAFE_0001});
        idle_masters();
        @(negedge clk);
        check("sim store merged", mem[32'h1000 >> 2], 32'h1234_BEEF);

        for (int k = 0; k < 8; k++) apply_vec(vecs[k], k);

        // Continuous contention: strict alternation, last table entry was I.
        acks_i = 0; acks_d = 0; n_gnt = 0; cyc = 0; pg = G_NONE;
        @(negedge clk);
        drive_i(32'h100);
        drive_d(32'h104, 32'h0, 1'b0, 4'hF);
        while (acks_i + acks_d < 10 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (pg == G_NONE && grant_o != G_NONE) begin
                check($sformatf("cont grant %0d", n_gnt), grant_o, (n_gnt % 2 == 0) ? G_D : G_I);
                n_gnt++;
            end
            pg = grant_o;
            if (iwb_ack_o) acks_i++;
            if (dwb_ack_o) acks_d++;
        end
        idle_masters();
        check("cont in budget", cyc < 100, 1'b1);
        check("cont ack split", {acks_i[7:0], acks_d[7:0]}, {8'd5, 8'd5});
        @(negedge clk);
        @(negedge clk);

        // Stalled slave: TIMEOUT=4 -> err in the fifth granted cycle.
        mem_no_ack = 1'b1;
        drive_d(32'h100, 32'h0, 1'b0, 4'hF);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("to grant c%0d", k), grant_o, G_D);
            check($sformatf("to err c%0d", k), {dwb_err_o, dwb_ack_o, iwb_err_o}, {k == 5, 2'b00});
            check($sformatf("to cyc/stb c%0d", k), {mwb_cyc_o, mwb_stb_o}, (k == 5) ? 2'b00 : 2'b11);
        end
        idle_masters();
        @(negedge clk);
        check("to back to idle", {grant_o, dwb_err_o}, {G_NONE, 1'b0});
        mem_no_ack = 1'b0;

        // Master abort of I, pending D served next.
        @(negedge clk);
        drive_i(32'h100);
        @(negedge clk);
        check("abort grant I", grant_o, G_I);
        iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
        drive_d(32'h100, 32'h0, 1'b0, 4'hF);
        #1;
        check("abort cyc drops", {mwb_cyc_o, iwb_ack_o, iwb_err_o}, 3'b000);
        @(negedge clk);
        check("abort idle", {grant_o, iwb_ack_o, iwb_err_o}, {G_NONE, 2'b00});
        @(negedge clk);
        check("abort then D", grant_o, G_D);
        @(negedge clk);
        check("abort d ack", {dwb_ack_o, iwb_ack_o, dwb_dat_o}, {2'b10, 32'h13});
        idle_masters();
        @(negedge clk);

        // Reset mid-transfer, then the first contention grants D again.
        drive_d(32'h100, 32'h0, 1'b0, 4'hF);
        @(negedge clk);
        check("rst pre grant", grant_o, G_D);
        #1 rst_n = 1'b0;
        #1;
        check_quiet("rst mid");
        @(negedge clk);
        idle_masters();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_i(32'h100);
        drive_d(32'h100, 32'h0, 1'b0, 4'hF);
        @(negedge clk);
        check("rst contention D", grant_o, G_D);
        @(negedge clk);
        check("rst d ack", {dwb_ack_o, iwb_ack_o}, 2'b10);
        dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst then I", grant_o, G_I);
        @(negedge clk);
        check("rst i ack", {iwb_ack_o, iwb_dat_o}, {1'b1, 32'h13});
        idle_masters();
        @(negedge clk);

        run_random(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
